// File: rtl/soc_top_pkg.sv
// soc_top_pkg: raster timing constants, colour type and colours shared by
// the soc_top board block and its video generator.
package soc_top_pkg;

   // Fixed porch/sync widths, in pixel clocks (horizontal) and lines (vertical)
   localparam int unsigned HFP    = 32'd40;
   localparam int unsigned HPULSE = 32'd48;
   localparam int unsigned HBP    = 32'd40;
   localparam int unsigned VFP    = 32'd13;
   localparam int unsigned VPULSE = 32'd3;
   localparam int unsigned VBP    = 32'd29;

   typedef logic [23:0] rgb_t;

   localparam rgb_t WHITE = 24'hFFFFFF;
   localparam rgb_t BLACK = 24'h000000;

   // Test-pattern grid rule: a pixel is on the grid when either active
   // coordinate is a multiple of 16
   function automatic logic on_grid(input logic [3:0] x_lo, input logic [3:0] y_lo);
      return (x_lo == 4'd0) || (y_lo == 4'd0);
   endfunction

endpackage

// File: rtl/soc_top_if.sv
// Board-level interfaces used by soc_top: the video output bundle and the
// hardware-support link.

interface video_if;
   logic        CLK;
   logic        HS;
   logic        VS;
   logic        BLANK;
   logic [23:0] RGB;

   modport master (output CLK, output HS, output VS, output BLANK, output RGB);
   modport slave  (input  CLK, input  HS, input  VS, input  BLANK, input  RGB);
endinterface

interface hws_if;
   logic [15:0] addr;
   logic        wr;
   logic        rd;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ack;

   modport master (output addr, output wr, output rd, output wdata,
                   input  rdata, input  ack);
   modport slave  (input  addr, input  wr, input  rd, input  wdata,
                   output rdata, output ack);
endinterface

// File: rtl/vga_gen.sv
// vga_gen: pixel/line counters, sync and blank decoding and the grid test
// pattern ("mire"). All video outputs are registered together so HS, VS,
// BLANK and RGB carry the same one-clock latency relative to the counters.
// o_frame_start flags the cycle where both counters are at 0.
module vga_gen
   import soc_top_pkg::*;
#(
   parameter int HDISP = 800,
   parameter int VDISP = 480
) (
   input  logic   i_clk,
   input  logic   i_rst_n,
   output logic   o_frame_start,
   video_if.master video_ifm
);

   localparam int HTOT = int'(HFP + HPULSE + HBP) + HDISP;
   localparam int VTOT = int'(VFP + VPULSE + VBP) + VDISP;
   localparam int HW   = $clog2(HTOT);
   localparam int VW   = $clog2(VTOT);

   // Window boundaries; the active region is the tail of each period
   localparam logic [HW-1:0] H_LAST    = HW'(HTOT - 1);
   localparam logic [HW-1:0] H_SYNC_LO = HW'(HFP);
   localparam logic [HW-1:0] H_SYNC_HI = HW'(HFP + HPULSE);
   localparam logic [HW-1:0] H_ACT     = HW'(HTOT - HDISP);
   localparam logic [VW-1:0] V_LAST    = VW'(VTOT - 1);
   localparam logic [VW-1:0] V_SYNC_LO = VW'(VFP);
   localparam logic [VW-1:0] V_SYNC_HI = VW'(VFP + VPULSE);
   localparam logic [VW-1:0] V_ACT     = VW'(VTOT - VDISP);

   logic [HW-1:0] r_hc;
   logic [VW-1:0] r_vc;

   logic          w_hs;
   logic          w_vs;
   logic          w_h_act;
   logic          w_v_act;
   logic          w_blank;
   logic [3:0]    w_x_lo;
   logic [3:0]    w_y_lo;
   rgb_t          w_rgb;

   logic          r_hs;
   logic          r_vs;
   logic          r_blank;
   rgb_t          r_rgb;

   // Pixel counter wraps at end of line; line counter advances on that wrap
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_hc <= '0;
         r_vc <= '0;
      end else if (r_hc == H_LAST) begin
         r_hc <= '0;
         if (r_vc == V_LAST) begin
            r_vc <= '0;
         end else begin
            r_vc <= r_vc + VW'(1);
         end
      end else begin
         r_hc <= r_hc + HW'(1);
      end
   end

   // Decode sync windows, active region and grid colour from the counters
   always_comb begin
      w_hs    = 1'b1;
      w_vs    = 1'b1;
      w_h_act = 1'b0;
      w_v_act = 1'b0;
      w_blank = 1'b0;
      w_x_lo  = 4'd0;
      w_y_lo  = 4'd0;
      w_rgb   = BLACK;

      w_hs    = ~((r_hc >= H_SYNC_LO) && (r_hc < H_SYNC_HI));
      w_vs    = ~((r_vc >= V_SYNC_LO) && (r_vc < V_SYNC_HI));
      w_h_act = (r_hc >= H_ACT);
      w_v_act = (r_vc >= V_ACT);
      w_blank = w_h_act && w_v_act;
      // Only the low nibble of each active coordinate matters for the grid
      w_x_lo  = 4'(r_hc - H_ACT);
      w_y_lo  = 4'(r_vc - V_ACT);

      if (!w_blank) begin
         w_rgb = BLACK;
      end else if (on_grid(w_x_lo, w_y_lo)) begin
         w_rgb = WHITE;
      end else begin
         w_rgb = BLACK;
      end
   end

   // Register all four video outputs on the same edge to keep them aligned
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_hs    <= 1'b1;
         r_vs    <= 1'b1;
         r_blank <= 1'b0;
         r_rgb   <= BLACK;
      end else begin
         r_hs    <= w_hs;
         r_vs    <= w_vs;
         r_blank <= w_blank;
         r_rgb   <= w_rgb;
      end
   end

   assign video_ifm.CLK   = i_clk;
   assign video_ifm.HS    = r_hs;
   assign video_ifm.VS    = r_vs;
   assign video_ifm.BLANK = r_blank;
   assign video_ifm.RGB   = r_rgb;

   assign o_frame_start = (r_hc == '0) && (r_vc == '0);

endmodule

// File: rtl/soc_top.sv
// soc_top: board top under the wrapper. Synchronises KEY[0] into the
// internal reset, drives the status LEDs (heartbeat, frame toggle, switch
// mirror), ties off the hardware-support link and hosts the test-pattern
// video generator.
// Build option: TOP_SIM_FAST_HEARTBEAT_EN shortens the heartbeat half-period
// to 5 000 clocks for simulation; undefined gives a 1 Hz blink at 50 MHz.
module soc_top
   import soc_top_pkg::*;
#(
   parameter int HDISP = 800,
   parameter int VDISP = 480
) (
   input  logic       FPGA_CLK1_50,
   input  logic [1:0] KEY,
   input  logic [3:0] SW,
   output logic [7:0] LED,
   hws_if.master      hws_ifm,
   video_if.master    video_ifm
);

`ifdef TOP_SIM_FAST_HEARTBEAT_EN
   localparam int unsigned HB_HALF = 32'd5000;
`else
   localparam int unsigned HB_HALF = 32'd25000000;
`endif
   localparam int HBW = 25;
   localparam logic [HBW-1:0] HB_LAST = HBW'(HB_HALF - 32'd1);

   logic           w_key_rst_n;
   logic [1:0]     r_rst_sync;
   logic           w_rst_n;
   logic           w_frame_start;
   logic [HBW-1:0] r_hb_cnt;
   logic           r_led_hb;
   logic           r_led_frame;
   logic [3:0]     r_led_sw;
   logic           w_unused;

   assign w_key_rst_n = KEY[0];

   // Reset synchroniser: asserts immediately, releases two edges after KEY[0] rises
   always_ff @(posedge FPGA_CLK1_50 or negedge w_key_rst_n) begin
      if (!w_key_rst_n) begin
         r_rst_sync <= 2'b00;
      end else begin
         r_rst_sync <= {r_rst_sync[0], 1'b1};
      end
   end

   assign w_rst_n = r_rst_sync[1];

   // Heartbeat: toggle LED[0] once every HB_HALF clocks
   always_ff @(posedge FPGA_CLK1_50 or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_hb_cnt <= '0;
         r_led_hb <= 1'b0;
      end else if (r_hb_cnt == HB_LAST) begin
         r_hb_cnt <= '0;
         r_led_hb <= ~r_led_hb;
      end else begin
         r_hb_cnt <= r_hb_cnt + HBW'(1);
         r_led_hb <= r_led_hb;
      end
   end

   // Frame toggle on LED[1] and registered switch mirror on LED[5:2]
   always_ff @(posedge FPGA_CLK1_50 or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_led_frame <= 1'b0;
         r_led_sw    <= 4'h0;
      end else begin
         r_led_frame <= r_led_frame ^ w_frame_start;
         r_led_sw    <= SW;
      end
   end

   assign LED = {2'b00, r_led_sw, r_led_frame, r_led_hb};

   // Hardware-support link is idle: every master-driven signal held low
   assign hws_ifm.addr  = 16'h0000;
   assign hws_ifm.wr    = 1'b0;
   assign hws_ifm.rd    = 1'b0;
   assign hws_ifm.wdata = 32'h0000_0000;

   // KEY[1] and the link's responses are not consumed
   assign w_unused = ^{KEY[1], hws_ifm.rdata, hws_ifm.ack};

   vga_gen #(
      .HDISP (HDISP),
      .VDISP (VDISP)
   ) u_vga_gen (
      .i_clk         (FPGA_CLK1_50),
      .i_rst_n       (w_rst_n),
      .o_frame_start (w_frame_start),
      .video_ifm     (video_ifm)
   );

endmodule

// File: tb/tb_soc_top.sv
// Bench for soc_top at 160x90: a cycle-indexed reference model derives every
// output from the frame position, plus period/width measurements of the
// sync, blank and LED waveforms, random switch activity and a random
// mid-frame reset.
module tb_soc_top;

   localparam int HDISP  = 160;
   localparam int VDISP  = 90;
   localparam int HFP    = 40;
   localparam int HPULSE = 48;
   localparam int HBP    = 40;
   localparam int VFP    = 13;
   localparam int VPULSE = 3;
   localparam int VBP    = 29;
   localparam int HTOT   = HFP + HPULSE + HBP + HDISP;
   localparam int VTOT   = VFP + VPULSE + VBP + VDISP;
   localparam int FRAME  = HTOT * VTOT;
`ifdef TOP_SIM_FAST_HEARTBEAT_EN
   localparam int HB_HALF = 5000;
`else
   localparam int HB_HALF = 25000000;
`endif

   logic       clk = 1'b0;
   logic [1:0] key;
   logic [3:0] sw;
   logic [7:0] led;

   video_if vif ();
   hws_if   hif ();

   assign hif.rdata = 32'h0000_0000;
   assign hif.ack   = 1'b0;

   soc_top #(
      .HDISP (HDISP),
      .VDISP (VDISP)
   ) dut (
      .FPGA_CLK1_50 (clk),
      .KEY          (key),
      .SW           (sw),
      .LED          (led),
      .hws_ifm      (hif),
      .video_ifm    (vif)
   );

   always #10 clk = ~clk;

   int n_vec  = 0;
   int n_fail = 0;
   int n_cur  = 0;

   int   hs_fall_n, vs_fall_n, led1_n, hb_n, blank_cnt, act_lines;
   bit   hs_seen, vs_seen, led1_seen, hb_seen;
   logic p_hs, p_vs, p_led1, p_hb;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Expected {HS, VS, BLANK, RGB} n cycles into a frame sequence
   function automatic logic [26:0] model_video(input int n);
      int h, v, x, y;
      logic hs, vs, act;
      logic [23:0] rgb;
      h   = n % HTOT;
      v   = (n / HTOT) % VTOT;
      hs  = !(h >= HFP && h < HFP + HPULSE);
      vs  = !(v >= VFP && v < VFP + VPULSE);
      act = (h >= HTOT - HDISP) && (v >= VTOT - VDISP);
      x   = h - (HTOT - HDISP);
      y   = v - (VTOT - VDISP);
      rgb = (act && ((x % 16) == 0 || (y % 16) == 0)) ? 24'hFFFFFF : 24'h000000;
      return {hs, vs, act, rgb};
   endfunction

   // Expected LEDs: one frame toggle at n=0 and every FRAME after; heartbeat
   // toggles once per HB_HALF counted edges (n+1 edges seen so far)
   function automatic logic [7:0] model_led(input int n, input logic [3:0] s);
      int frames, hbt;
      frames = n / FRAME + 1;
      hbt    = (n + 1) / HB_HALF;
      return {2'b00, s, 1'(frames % 2), 1'(hbt % 2)};
   endfunction

   function automatic int pix_n(input int x, input int y);
      return (VTOT - VDISP + y) * HTOT + (HTOT - HDISP) + x;
   endfunction

   task automatic check_reset(input string tag);
      check_eq({tag, "_video"}, {vif.HS, vif.VS, vif.BLANK, vif.RGB}, {1'b1, 1'b1, 1'b0, 24'h000000});
      check_eq({tag, "_led"}, led, 8'h00);
   endtask

   task automatic cycle_check(input int n, input logic [3:0] s);
      if (n == 0) begin
         p_hs = 1'b1; p_vs = 1'b1; p_led1 = 1'b0; p_hb = 1'b0;
         hs_seen = 1'b0; vs_seen = 1'b0; led1_seen = 1'b0; hb_seen = 1'b0;
         blank_cnt = 0; act_lines = 0;
      end
      check_eq("video", {vif.HS, vif.VS, vif.BLANK, vif.RGB}, model_video(n));
      check_eq("led", led, model_led(n, s));
      check_eq("hws_idle", {hif.addr, hif.wr, hif.rd, hif.wdata}, 64'h0);
      check_eq("vclk", vif.CLK, clk);
      if (!vif.BLANK) check_eq("rgb_blank", vif.RGB, 24'h000000);
      if (n == pix_n(0, 5))  check_eq("px_x0_y5", vif.RGB, 24'hFFFFFF);
      if (n == pix_n(16, 7)) check_eq("px_x16_y7", vif.RGB, 24'hFFFFFF);
      if (n == pix_n(5, 5))  check_eq("px_x5_y5", vif.RGB, 24'h000000);

      if (vif.BLANK) blank_cnt++;
      if (p_hs && !vif.HS) begin
         if (hs_seen) begin
            check_eq("hs_period", n - hs_fall_n, HTOT);
            check_eq("blank_per_line", (blank_cnt == 0) || (blank_cnt == HDISP), 1'b1);
            if (blank_cnt != 0) act_lines++;
         end
         hs_fall_n = n; hs_seen = 1'b1; blank_cnt = 0;
      end
      if (!p_hs && vif.HS && hs_seen) check_eq("hs_low", n - hs_fall_n, HPULSE);

      if (p_vs && !vif.VS) begin
         if (vs_seen) begin
            check_eq("vs_period", n - vs_fall_n, FRAME);
            check_eq("active_lines", act_lines, VDISP);
         end
         vs_fall_n = n; vs_seen = 1'b1; act_lines = 0;
      end
      if (!p_vs && vif.VS && vs_seen) check_eq("vs_low", n - vs_fall_n, VPULSE * HTOT);

      if (led[1] !== p_led1) begin
         if (led1_seen) check_eq("frame_toggle", n - led1_n, FRAME);
         led1_n = n; led1_seen = 1'b1;
      end
      if (led[0] !== p_hb) begin
         if (hb_seen) check_eq("hb_period", n - hb_n, HB_HALF);
         hb_n = n; hb_seen = 1'b1;
      end
      p_hs = vif.HS; p_vs = vif.VS; p_led1 = led[1]; p_hb = led[0];
   endtask

   task automatic run(input int count);
      logic [3:0] s;
      for (int i = 0; i < count; i++) begin
         s = sw;
         @(posedge clk);
         #1;
         cycle_check(n_cur, s);
         n_cur++;
         if ($urandom_range(0, 15) == 0) sw = 4'($urandom);
      end
   endtask

   task automatic release_reset(input string tag);
      @(negedge clk);
      key[0] = 1'b1;
      @(posedge clk); #1; check_reset({tag, "_e1"});
      @(posedge clk); #1; check_reset({tag, "_e2"});
      n_cur = 0;
   endtask

   initial begin
      key = 2'b10;
      sw  = 4'h0;
      #128;
      check_reset("rst_hold");
      release_reset("rel");
      run(44000);

      sw = 4'b1010;
      run(1);
      check_eq("sw_1010", led[5:2], 4'b1010);
      check_eq("led_hi_zero", led[7:6], 2'b00);

      run($urandom_range(100, 5000));

      @(negedge clk);
      key[0] = 1'b0;
      #1;
      check_reset("mid_async");
      repeat (3) @(posedge clk);
      #1;
      check_reset("mid_hold");
      release_reset("mid_rel");
      run(3000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
